// File: rtl/ft_pkg.sv
// Shared definitions for the FT2232H sync-FIFO receive path.
// FT_RX_CHECKSUM_EN: when defined, each packet ends with an XOR checksum byte.
package ft_pkg;

   localparam int         FT_USB_DATA_WIDTH = 8;
   localparam int         FT_ADDR_WIDTH     = 4;
   localparam int         FT_DATA_BYTES     = 3;
   localparam logic [3:0] FT_HEADER_NIBBLE  = 4'hA;

`ifdef FT_RX_CHECKSUM_EN
   localparam int FT_CSUM_BYTES = 1;
`else
   localparam int FT_CSUM_BYTES = 0;
`endif

   // Header + payload (+ checksum) for the default payload size.
   localparam int FT_PKT_LEN = 1 + FT_DATA_BYTES + FT_CSUM_BYTES;

   // Command address map consumed by the configuration logic in top.
   localparam logic [3:0] ADDR_ADF_RAMP_LO = 4'h0;
   localparam logic [3:0] ADDR_ADF_RAMP_HI = 4'h1;
   localparam logic [3:0] ADDR_RF_ENABLES  = 4'h2;
   localparam logic [3:0] ADDR_ADC_CH_SEL  = 4'h3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OE    = 2'd1,
      ST_READ  = 2'd2,
      ST_STALL = 2'd3
   } ft_state_e;

   function automatic int pkt_len(input int data_bytes);
      return 1 + data_bytes + FT_CSUM_BYTES;
   endfunction

endpackage

// File: rtl/ft_rx_pkt_asm.sv
// Packet assembler: byte index, header resync, payload shift register,
// optional checksum check (FT_RX_CHECKSUM_EN) and saturating error counter.
module ft_rx_pkt_asm
   import ft_pkg::*;
#(
   parameter int         USB_DATA_WIDTH = FT_USB_DATA_WIDTH,
   parameter int         ADDR_WIDTH     = FT_ADDR_WIDTH,
   parameter int         DATA_BYTES     = FT_DATA_BYTES,
   parameter logic [3:0] HEADER_NIBBLE  = FT_HEADER_NIBBLE
) (
   input  logic                      clk_i,
   input  logic                      rst_n,
   input  logic                      i_cap,
   input  logic [USB_DATA_WIDTH-1:0] i_byte,
   output logic                      o_done,
   output logic [ADDR_WIDTH-1:0]     o_addr,
   output logic [8*DATA_BYTES-1:0]   o_data,
   output logic [8*DATA_BYTES-1:0]   o_data_nxt,
   output logic [7:0]                o_err_cnt
);

   localparam int             DW   = 8*DATA_BYTES;
   localparam int             LEN  = pkt_len(DATA_BYTES);
   localparam int             IW   = $clog2(LEN) + 1;
   localparam logic [IW-1:0]  LAST = IW'(LEN - 1);

   logic [IW-1:0]         r_idx;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DW-1:0]         r_data;
   logic [7:0]            r_err;

   logic w_idx0, w_last, w_hdr_ok, w_hdr_err, w_pkt_err, w_payload;

   assign w_idx0    = (r_idx == '0);
   assign w_last    = (r_idx == LAST);
   assign w_hdr_ok  = (i_byte[USB_DATA_WIDTH-1 -: 4] == HEADER_NIBBLE);
   assign w_hdr_err = i_cap & w_idx0 & ~w_hdr_ok;

`ifdef FT_RX_CHECKSUM_EN
   logic [USB_DATA_WIDTH-1:0] r_csum;

   // Running XOR of header and payload, compared against the trailing byte.
   always_ff @(posedge clk_i) begin
      if (!rst_n)
         r_csum <= '0;
      else if (i_cap)
         r_csum <= w_idx0 ? i_byte : (r_csum ^ i_byte);
   end

   assign w_payload  = ~w_idx0 & ~w_last;
   assign w_pkt_err  = i_cap & w_last & (r_csum != i_byte);
   assign o_done     = i_cap & w_last & (r_csum == i_byte);
   assign o_data_nxt = r_data;
`else
   assign w_payload  = ~w_idx0;
   assign w_pkt_err  = 1'b0;
   assign o_done     = i_cap & w_last;
   assign o_data_nxt = {r_data[DW-USB_DATA_WIDTH-1:0], i_byte};
`endif

   // Index/shift assembly; a bad header keeps the index at 0 to resync.
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         r_idx  <= '0;
         r_addr <= '0;
         r_data <= '0;
         r_err  <= '0;
      end else begin
         if ((w_hdr_err || w_pkt_err) && (r_err != 8'hFF))
            r_err <= r_err + 8'd1;
         if (i_cap) begin
            if (w_idx0) begin
               if (w_hdr_ok) begin
                  r_addr <= i_byte[ADDR_WIDTH-1:0];
                  r_idx  <= IW'(1);
               end
            end else begin
               r_idx <= w_last ? '0 : (r_idx + IW'(1));
               if (w_payload)
                  r_data <= {r_data[DW-USB_DATA_WIDTH-1:0], i_byte};
            end
         end
      end
   end

   assign o_addr    = r_addr;
   assign o_data    = r_data;
   assign o_err_cnt = r_err;

endmodule

// File: rtl/ft_rx_cmd.sv
// FT2232H sync-245 receive path: OE#/RD# sequencing, packet assembly and a
// one-entry command holding register on a valid/ready interface.
// FT_RX_CHECKSUM_EN: when defined, packets carry a trailing XOR checksum byte.
//
// state | meaning
// IDLE  | bus released, waiting for RXF#
// OE    | OE# asserted one cycle before the first RD#
// READ  | OE# and RD# asserted, one byte per cycle
// STALL | packet complete but holding full; bus released until it drains
module ft_rx_cmd
   import ft_pkg::*;
#(
   parameter int         USB_DATA_WIDTH = FT_USB_DATA_WIDTH,
   parameter int         ADDR_WIDTH     = FT_ADDR_WIDTH,
   parameter int         DATA_BYTES     = FT_DATA_BYTES,
   parameter logic [3:0] HEADER_NIBBLE  = FT_HEADER_NIBBLE
) (
   input  logic                      clk_i,
   input  logic                      rst_n,
   input  logic [USB_DATA_WIDTH-1:0] ft_data_i,
   input  logic                      ft_rxf_n_i,
   output logic                      ft_oe_n_o,
   output logic                      ft_rd_n_o,
   output logic                      rx_busy_o,
   output logic                      cmd_valid_o,
   input  logic                      cmd_ready_i,
   output logic [ADDR_WIDTH-1:0]     cmd_addr_o,
   output logic [8*DATA_BYTES-1:0]   cmd_data_o,
   output logic [7:0]                err_cnt_o
);

   localparam int DW = 8*DATA_BYTES;

   ft_state_e             r_state;
   logic                  r_oe_n, r_rd_n, r_busy, r_valid;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DW-1:0]         r_data;

   logic                  w_cap, w_done, w_hold_free;
   logic [ADDR_WIDTH-1:0] w_asm_addr;
   logic [DW-1:0]         w_asm_data, w_asm_data_nxt;

   assign w_cap       = ~r_rd_n & ~ft_rxf_n_i;
   assign w_hold_free = ~r_valid | cmd_ready_i;

   ft_rx_pkt_asm #(
      .USB_DATA_WIDTH (USB_DATA_WIDTH),
      .ADDR_WIDTH     (ADDR_WIDTH),
      .DATA_BYTES     (DATA_BYTES),
      .HEADER_NIBBLE  (HEADER_NIBBLE)
   ) u_asm (
      .clk_i      (clk_i),
      .rst_n      (rst_n),
      .i_cap      (w_cap),
      .i_byte     (ft_data_i),
      .o_done     (w_done),
      .o_addr     (w_asm_addr),
      .o_data     (w_asm_data),
      .o_data_nxt (w_asm_data_nxt),
      .o_err_cnt  (err_cnt_o)
   );

   // Bus sequencing FSM; RD# is dropped on the completing edge when stalling
   // so the FIFO is never strobed for a byte we cannot take.
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_oe_n  <= 1'b1;
         r_rd_n  <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!ft_rxf_n_i) begin
                  r_state <= ST_OE;
                  r_oe_n  <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            ST_OE: begin
               if (!ft_rxf_n_i) begin
                  r_state <= ST_READ;
                  r_rd_n  <= 1'b0;
               end else begin
                  r_state <= ST_IDLE;
                  r_oe_n  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            ST_READ: begin
               if (ft_rxf_n_i || (w_done && !w_hold_free)) begin
                  r_state <= ft_rxf_n_i ? ST_IDLE : ST_STALL;
                  r_oe_n  <= 1'b1;
                  r_rd_n  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            ST_STALL: begin
               if (w_hold_free)
                  r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_oe_n  <= 1'b1;
               r_rd_n  <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Command holding register; a completing packet reloads it on the same
   // edge the previous command is accepted.
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else if (w_done && w_hold_free) begin
         r_valid <= 1'b1;
         r_addr  <= w_asm_addr;
         r_data  <= w_asm_data_nxt;
      end else if ((r_state == ST_STALL) && w_hold_free) begin
         r_valid <= 1'b1;
         r_addr  <= w_asm_addr;
         r_data  <= w_asm_data;
      end else if (r_valid && cmd_ready_i) begin
         r_valid <= 1'b0;
      end
   end

   assign ft_oe_n_o   = r_oe_n;
   assign ft_rd_n_o   = r_rd_n;
   assign rx_busy_o   = r_busy;
   assign cmd_valid_o = r_valid;
   assign cmd_addr_o  = r_addr;
   assign cmd_data_o  = r_data;

endmodule

// File: tb/tb_ft_rx_cmd.sv
// Directed bench for ft_rx_cmd: FIFO model feeding bytes, scoreboard of
// expected commands popped on each valid/ready handshake.
module tb_ft_rx_cmd;
   import ft_pkg::*;

   localparam int PL = FT_PKT_LEN;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  ft_data;
   logic        ft_rxf_n;
   logic        cmd_ready;
   logic        ft_oe_n_o, ft_rd_n_o, rx_busy_o, cmd_valid_o;
   logic [3:0]  cmd_addr_o;
   logic [23:0] cmd_data_o;
   logic [7:0]  err_cnt_o;

   int total = 0;
   int bad   = 0;
   int consumed = 0;
   int c0;

   logic [7:0]  fifo_q[$];
   logic [7:0]  pkt_q[$];
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   ft_rx_cmd dut (
      .clk_i       (clk),
      .rst_n       (rst_n),
      .ft_data_i   (ft_data),
      .ft_rxf_n_i  (ft_rxf_n),
      .ft_oe_n_o   (ft_oe_n_o),
      .ft_rd_n_o   (ft_rd_n_o),
      .rx_busy_o   (rx_busy_o),
      .cmd_valid_o (cmd_valid_o),
      .cmd_ready_i (cmd_ready),
      .cmd_addr_o  (cmd_addr_o),
      .cmd_data_o  (cmd_data_o),
      .err_cnt_o   (err_cnt_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_ifc();
      ft_rxf_n = (fifo_q.size() == 0);
      ft_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
   endtask

   // One clock: scoreboard the handshake about to happen, then let the FIFO
   // model retire the byte the DUT strobed on this edge.
   task automatic tick();
      logic        rd_s, rxf_s;
      logic [31:0] want;
      rd_s  = ft_rd_n_o;
      rxf_s = ft_rxf_n;
      if (cmd_valid_o === 1'b1 && cmd_ready) begin
         want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
         check("cmd", 32'({cmd_addr_o, cmd_data_o}), want);
      end
      @(posedge clk);
      #1;
      if (rd_s === 1'b0 && !rxf_s) begin
         void'(fifo_q.pop_front());
         consumed++;
      end
      drive_ifc();
   endtask

   task automatic make_pkt(input logic [3:0] a, input logic [23:0] d, input bit want);
      pkt_q.push_back({FT_HEADER_NIBBLE, a});
      for (int i = 0; i < 3; i++)
         pkt_q.push_back(d[23-8*i -: 8]);
`ifdef FT_RX_CHECKSUM_EN
      begin
         logic [7:0] x;
         x = {FT_HEADER_NIBBLE, a} ^ d[23:16] ^ d[15:8] ^ d[7:0];
         pkt_q.push_back(x);
      end
`endif
      if (want)
         exp_q.push_back(32'({a, d}));
   endtask

   task automatic move_bytes(input int n);
      for (int i = 0; i < n && pkt_q.size() != 0; i++)
         fifo_q.push_back(pkt_q.pop_front());
      drive_ifc();
   endtask

   task automatic push_raw(input logic [7:0] b);
      fifo_q.push_back(b);
      drive_ifc();
   endtask

   task automatic run_idle(input string tag);
      int n;
      n = 0;
      while (n < 1000 && !(fifo_q.size() == 0 && exp_q.size() == 0 &&
                           cmd_valid_o === 1'b0 && ft_oe_n_o === 1'b1)) begin
         tick();
         n++;
      end
      check(tag, 32'(n < 1000), 32'd1);
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_ctl"}, 32'({ft_oe_n_o, ft_rd_n_o, rx_busy_o, cmd_valid_o, cmd_addr_o, err_cnt_o}),
            32'({1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00}));
      check({tag, "_data"}, 32'(cmd_data_o), 32'h0);
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_ready = 1'b1;
      ft_rxf_n  = 1'b1;
      ft_data   = 8'h00;
      @(posedge clk);
      #1;
      repeat (3) tick();
      check_reset_outs("rst0");
      rst_n = 1'b1;
      tick();

      // Single packet: OE# leads RD# by one cycle, command one cycle after last byte
      make_pkt(4'h3, 24'h123456, 1'b1);
      move_bytes(PL);
      check("t1_idle", 32'({ft_oe_n_o, ft_rd_n_o}), 32'b11);
      tick();
      check("t1_oe_first", 32'({ft_oe_n_o, ft_rd_n_o, rx_busy_o}), 32'b011);
      tick();
      check("t1_rd", 32'({ft_oe_n_o, ft_rd_n_o, rx_busy_o}), 32'b001);
      repeat (PL - 1) tick();
      check("t1_not_yet", 32'(cmd_valid_o), 32'd0);
      tick();
      check("t1_valid", 32'({cmd_valid_o, cmd_addr_o, cmd_data_o}), 32'({1'b1, 4'h3, 24'h123456}));
      tick();
      check("t1_pulse", 32'(cmd_valid_o), 32'd0);
      check("t1_err", 32'(err_cnt_o), 32'd0);
      run_idle("t1_done");

      // Two bad header bytes before a good packet
      push_raw(8'h00);
      push_raw(8'h7F);
      make_pkt(4'h1, 24'h000001, 1'b1);
      move_bytes(PL);
      run_idle("t2_done");
      check("t2_err", 32'(err_cnt_o), 32'd2);

      // RXF# deasserts mid-packet for 5 cycles, then the packet resumes
      make_pkt(4'h5, 24'h112233, 1'b1);
      c0 = consumed;
      move_bytes(2);
      for (int i = 0; i < 20 && consumed < c0 + 2; i++) tick();
      check("t3_two", 32'(consumed - c0), 32'd2);
      repeat (5) tick();
      check("t3_pause", 32'({ft_oe_n_o, ft_rd_n_o, rx_busy_o, cmd_valid_o}), 32'b1100);
      move_bytes(PL);
      run_idle("t3_done");
      check("t3_err", 32'(err_cnt_o), 32'd2);

      // Consumer not ready: second packet stalls the bus with RD# high
      cmd_ready = 1'b0;
      c0 = consumed;
      make_pkt(4'h2, 24'hAABBCC, 1'b1);
      make_pkt(4'h4, 24'hDDEEFF, 1'b1);
      make_pkt(4'h6, 24'h010101, 1'b1);
      move_bytes(3*PL);
      for (int i = 0; i < 100 && consumed < c0 + 2*PL; i++) tick();
      check("t4_rd_hi", 32'({ft_oe_n_o, ft_rd_n_o, rx_busy_o}), 32'b110);
      check("t4_cnt", 32'(consumed - c0), 32'(2*PL));
      repeat (6) tick();
      check("t4_hold_cnt", 32'(consumed - c0), 32'(2*PL));
      check("t4_held", 32'({cmd_valid_o, cmd_addr_o, cmd_data_o}), 32'({1'b1, 4'h2, 24'hAABBCC}));
      cmd_ready = 1'b1;
      tick();
      check("t4_b2b", 32'({cmd_valid_o, cmd_addr_o, cmd_data_o}), 32'({1'b1, 4'h4, 24'hDDEEFF}));
      run_idle("t4_done");

      // Error counter saturation
      for (int i = 0; i < 256; i++) push_raw(8'h5C);
      run_idle("sat_done");
      check("sat_err", 32'(err_cnt_o), 32'd255);

      // Reset mid-packet discards the partial packet
      make_pkt(4'h7, 24'h999999, 1'b0);
      c0 = consumed;
      move_bytes(2);
      for (int i = 0; i < 20 && consumed < c0 + 2; i++) tick();
      pkt_q.delete();
      rst_n = 1'b0;
      tick();
      check_reset_outs("rst_mid");
      tick();
      check_reset_outs("rst_mid2");
      rst_n = 1'b1;
      tick();
      make_pkt(4'h8, 24'h010203, 1'b1);
      move_bytes(PL);
      run_idle("t5_done");
      check("t5_err", 32'(err_cnt_o), 32'd0);

`ifdef FT_RX_CHECKSUM_EN
      // Good checksum then bad checksum
      push_raw(8'hA2); push_raw(8'h00); push_raw(8'h00); push_raw(8'h05); push_raw(8'hA7);
      exp_q.push_back(32'({4'h2, 24'h000005}));
      run_idle("cs_good");
      check("cs_good_err", 32'(err_cnt_o), 32'd0);
      push_raw(8'hA2); push_raw(8'h00); push_raw(8'h00); push_raw(8'h05); push_raw(8'hA6);
      run_idle("cs_bad");
      check("cs_bad_err", 32'(err_cnt_o), 32'd1);
`endif

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
